// File: rtl/pipe_mem_arbiter.sv
// Shares one memory bus between the IF and MEM pipeline stages.
// A MEM access (load/store) is served before an IF fetch in the same pipeline
// cycle. stall holds the pipeline until both accesses are done, then drops
// for one RELEASE cycle so the pipeline can advance.
// Optional feature macro: ARB_TIMEOUT_EN (bus_ack wait timeout with sticky err).
module pipe_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        m_wmem,
  input  logic        m_m2reg,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err
);

  // TIMEOUT has to fit the 8-bit wait counter.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gen_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StMAcc, StIAcc, StRelease} state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic        m_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       expired;
  assign expired = (cnt_q == TimeoutLast);
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  // A simultaneous store and load request is treated as a store.
  assign m_req = m_wmem | m_m2reg;

  // Freeze the pipeline unless releasing, while requests or an access are pending.
  assign stall = (state_q != StRelease) &
                 (m_req | if_req | (state_q == StMAcc) | (state_q == StIAcc));

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign m_rdata   = m_rdata_q;

  // Next-state and bus register loading.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    m_rdata_d   = m_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q + 8'd1;
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m_req) begin
          state_d     = StMAcc;
          bus_req_d   = 1'b1;
          bus_we_d    = m_wmem;
          bus_addr_d  = m_addr;
          bus_wdata_d = m_wdata;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (if_req) begin
          state_d    = StIAcc;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
        end
      end
      StMAcc: begin
`ifdef ARB_TIMEOUT_EN
        if (bus_ack || expired) begin
          if (!bus_we_q) m_rdata_d = bus_ack ? bus_rdata : 32'd0;
          if (!bus_ack) err_d = 1'b1;
`else
        if (bus_ack) begin
          if (!bus_we_q) m_rdata_d = bus_rdata;
`endif
          // Chain the fetch straight on without an idle bus cycle.
          if (if_req) begin
            state_d    = StIAcc;
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = if_addr;
`ifdef ARB_TIMEOUT_EN
            cnt_d      = 8'd0;
`endif
          end else begin
            state_d   = StRelease;
            bus_req_d = 1'b0;
          end
        end
      end
      StIAcc: begin
`ifdef ARB_TIMEOUT_EN
        if (bus_ack || expired) begin
          if_rdata_d = bus_ack ? bus_rdata : 32'd0;
          if (!bus_ack) err_d = 1'b1;
`else
        if (bus_ack) begin
          if_rdata_d = bus_rdata;
`endif
          state_d   = StRelease;
          bus_req_d = 1'b0;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State and output registers; clr drops any in-flight access at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      m_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      m_rdata_q   <= m_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule
